// File: rtl/hack_cpu_core.sv
// hack_cpu_core
// Control and register stage of the Hack CPU. Decodes each 16-bit Hack
// instruction into ALU controls and operands, consumes the external ALU's
// result and flags, and updates the A, D, PC and retired-count registers.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   instruction       instruction word fetched at pc
//   instr_valid       1 = execute this cycle, 0 = stall (all registers hold)
//   inM               data memory read value at addressM
//   outM / writeM     data memory write value / write enable
//   addressM          data memory address (A[14:0])
//   pc                address of the current instruction
//   retired           executed-instruction count, wraps mod 2^16
//   alu_x / alu_y     ALU operands (D, and A or inM)
//   alu_zx..alu_no    ALU control bits
//   alu_out/zr/ng     ALU result and flags
module hack_cpu_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic        instr_valid,
  input  logic [15:0] inM,
  output logic [15:0] outM,
  output logic        writeM,
  output logic [14:0] addressM,
  output logic [14:0] pc,
  output logic [15:0] retired,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng
);

  logic [15:0] r_a;
  logic [15:0] r_d;
  logic [14:0] r_pc;
  logic [15:0] r_retired;

  logic w_is_c;
  logic w_d1;
  logic w_d2;
  logic w_d3;
  logic w_jump;
  logic w_unused_bits;

  assign w_is_c = instruction[15];
  assign w_d1   = w_is_c & instruction[5];
  assign w_d2   = w_is_c & instruction[4];
  assign w_d3   = w_is_c & instruction[3];

  // Bits [14:13] of a C-instruction carry no meaning.
  assign w_unused_bits = ^instruction[14:13];

  assign w_jump = w_is_c & ((instruction[2] & alu_ng) |
                            (instruction[1] & alu_zr) |
                            (instruction[0] & ~alu_ng & ~alu_zr));

  always_comb begin
    {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = '0;
    if (w_is_c) begin
      {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = instruction[11:6];
    end
  end

  assign alu_x    = r_d;
  assign alu_y    = (w_is_c & instruction[12]) ? inM : r_a;
  assign outM     = alu_out;
  assign addressM = r_a[14:0];
  assign pc       = r_pc;
  assign retired  = r_retired;

  // Gated by reset so no write can slip out while the core is held in reset.
  assign writeM = ~reset & instr_valid & w_d3;

  // Jump target and memory address both use the pre-edge A, so AM=... and
  // A=...;JMP behave correctly with the non-blocking update of r_a.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a       <= '0;
      r_d       <= '0;
      r_pc      <= '0;
      r_retired <= '0;
    end else if (instr_valid) begin
      if (!w_is_c) begin
        r_a <= instruction;
      end else if (w_d1) begin
        r_a <= alu_out;
      end
      if (w_d2) begin
        r_d <= alu_out;
      end
      r_pc      <= w_jump ? r_a[14:0] : r_pc + 15'd1;
      r_retired <= r_retired + 16'd1;
    end
  end

endmodule

// File: doc/hack_cpu_core.md
# hack_cpu_core

Control and register stage of the Hack CPU. It sits directly around the ALU: it decodes each 16-bit Hack instruction into the ALU's six control bits and operands, then consumes the ALU's `out`, `zr` and `ng` results. With those it updates the A, D and PC registers, drives the data-memory write port and evaluates jump conditions. The ALU itself is external and connects through the `alu_*` ports.

## Interface
- No parameters. The word width is fixed at 16 bits and the address width at 15 bits.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- instruction  in  16  current instruction word from instruction memory
- instr_valid  in  1  instruction is valid this cycle; 0 stalls the core
- inM  in  16  data memory read value at addressM
- outM  out  16  data memory write value; always equals alu_out
- writeM  out  1  data memory write enable for this cycle
- addressM  out  15  data memory address; equals A[14:0]
- pc  out  15  address of the current instruction
- retired  out  16  count of executed instructions, wraps modulo 2^16
- alu_x  out  16  ALU x operand; equals D
- alu_y  out  16  ALU y operand; A when a-bit=0, inM when a-bit=1
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control bits
- alu_out  in  16  ALU result
- alu_zr, alu_ng  in  1 each  ALU zero and negative flags

## Operation
- Registers: A (16 bits), D (16 bits), PC (15 bits), retired (16 bits). All other outputs are combinational from these registers and the inputs.
- An instruction with instruction[15]=0 is an A-instruction:
  - A <= instruction at the edge.
  - ALU control bits are all forced to 0.
  - writeM=0, no jump.
- An instruction with instruction[15]=1 is a C-instruction. Field layout:
  - [12] a-bit (y-operand select).
  - [11:6] = zx, nx, zy, ny, f, no, passed straight to the alu_* control outputs.
  - [5:3] = dest bits d1 (write A), d2 (write D), d3 (write M).
  - [2:0] = jump bits j1 (out<0), j2 (out=0), j3 (out>0).
  - Bits [14:13] are ignored and not checked.
- Jump taken = (j1 & alu_ng) | (j2 & alu_zr) | (j3 & ~alu_ng & ~alu_zr). A taken jump sets PC <= A[14:0], using A's value before the edge. Otherwise PC <= PC+1.
- writeM = instr_valid & instruction[15] & d3. The write goes to the pre-edge addressM.
- Simultaneous d1 and d3 (e.g. AM=...): memory is written at the old A, and A takes alu_out at the edge.
- Simultaneous d1 and a jump: the jump target is the old A.
- Stall: when instr_valid=0, A, D, PC and retired all hold, writeM=0, and the alu_* outputs still follow the instruction.
- PC wraps from 0x7FFF to 0x0000. retired wraps from 0xFFFF to 0x0000.

## Timing
- Single-cycle execution: decode, ALU evaluation and memory write-enable are combinational within the cycle. All register updates occur at the rising clk edge when instr_valid=1, so throughput is 1 instruction per valid cycle.
- While reset=1, asynchronously and without waiting for a clock edge:
  - A=0, D=0, pc=0, retired=0.
  - addressM=0, alu_x=0.
  - writeM is forced to 0.
- Reset asserted mid-instruction discards that instruction. No register or memory update occurs.
- The first instruction fetched after reset deasserts is at pc=0.
- Instruction memory is read combinationally at pc, and the result must be stable before the next edge.

## Test plan
The bench instantiates the existing ALU on the alu_* ports.
- Reset: assert reset mid-cycle -> pc=0, addressM=0, alu_x=0, writeM=0, retired=0 immediately, without a clock edge.
- Load and copy: 0x0015 (@21), then 0xEC10 (D=A) -> after 2 edges addressM=21, alu_x=21, pc=2, retired=2.
- Memory write: with A=21 and D=21, apply 0xE7C8 (M=D+1) -> writeM=1, outM=22, addressM=21 in-cycle; after the edge D=21 is unchanged and pc advances by 1.
- Jumps, with A=100 throughout:
  - D=21, apply 0xE301 (D;JGT) -> pc=100.
  - Apply 0xEA90 (D=0), then 0xE301 -> no jump, pc increments.
  - With D=0, apply 0xE302 (D;JEQ) -> pc=100.
- Stall: hold instr_valid=0 for 3 edges while applying 0xE7C8 -> writeM=0, and pc, A, D and retired are unchanged.
- Wrap and simultaneous update:
  - 0x7FFF (@32767), then 0xEA87 (0;JMP) -> pc=32767; one further valid edge with a non-jump instruction -> pc=0.
  - With A=5 and inM=9, apply 0xFCA8 (AM=M-1) -> writeM=1, addressM=5, outM=8; after the edge A=8.
